mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_D_STREAK, default 4: max consecutive data grants while a fetch is pending.
REQ-002 SHALL have parameter TIMEOUT, default 16: cycles m_req may stay high without m_ack before abort.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-005 SHALL have port i_req  input  1  fetch request; held until i_valid.
REQ-006 SHALL have port i_addr  input  32  fetch byte address.
REQ-007 SHALL have port i_rdata  output  32  fetched instruction; meaningful only with i_valid.
REQ-008 SHALL have port i_valid  output  1  one-cycle fetch completion pulse.
REQ-009 SHALL have port d_req  input  1  load/store request from MEM stage; held until d_valid.
REQ-010 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have port d_addr  input  32  data byte address.
REQ-012 SHALL have port d_wdata  input  32  store data.
REQ-013 SHALL have port d_rdata  output  32  load data; meaningful only with d_valid.
REQ-014 SHALL have port d_valid  output  1  one-cycle data completion pulse.
REQ-015 SHALL have port err  output  1  qualifies the concurrent i_valid/d_valid pulse as a timeout abort.
REQ-016 SHALL have port m_req  output  1  request to the shared single-port memory.
REQ-017 SHALL have ports m_we (output 1), m_addr (output 32) and m_wdata (output 32): registered memory command.
REQ-018 SHALL have port m_rdata  input  32  memory read data, valid with m_ack.
REQ-019 SHALL have port m_ack  input  1  memory completion, one cycle, only while m_req is high.

Function
REQ-020 SHALL implement FSM states IDLE, SERVE_I, SERVE_D; exactly one transaction outstanding.
REQ-021 In IDLE, the FSM SHALL go to SERVE_D if d_req and (streak < MAX_D_STREAK or !i_req), else to SERVE_I if i_req, else stay in IDLE.
REQ-022 On entering SERVE_x, the FSM SHALL latch the requester's address, we and wdata into m_addr/m_we/m_wdata; m_we = 0 for fetches.
REQ-023 m_req SHALL be 1 exactly while in SERVE_I or SERVE_D, and its value SHALL be decoded from registered state.
REQ-024 In SERVE_x with m_ack = 1, the FSM SHALL pass x_valid = 1 and x_rdata = m_rdata combinationally in that cycle, with err = 0, then return to IDLE.
REQ-025 Minimum latency SHALL be request seen in IDLE at cycle N, m_req at N+1, valid at N+1 if m_ack arrives immediately.
REQ-026 There SHALL be an idle cycle between transactions; a requester deasserts req the cycle after its valid, so it is never re-granted spuriously.
REQ-027 The streak counter SHALL increment (saturating) on each data grant made while i_req = 1, and SHALL clear on a fetch grant or on a data grant with i_req = 0.
REQ-028 The watchdog SHALL count cycles in SERVE_x, and on reaching TIMEOUT without m_ack it SHALL pulse x_valid with err = 1, set x_rdata = 0, and return to IDLE.
REQ-029 m_ack in IDLE SHALL be ignored and SHALL produce no valid.
REQ-030 i_valid and d_valid SHALL never be 1 together; err SHALL be 0 whenever both are 0.
REQ-031 On a simultaneous i_req and d_req with streak = 0, the arbiter SHALL grant data.

Reset
REQ-032 While reset = 0, the FSM SHALL be in IDLE with streak = 0, watchdog = 0, and m_req, m_we, m_addr, m_wdata, i_valid, d_valid, err all 0.
REQ-033 If reset is asserted mid-transaction, m_req SHALL drop asynchronously and no valid SHALL be issued for the aborted access; the requester re-requests after release.

Structure
REQ-034 The shared package riscv_mem_pkg SHALL hold the state enum arb_state_t, ADDR_W = 32, DATA_W = 32 and the MAX_D_STREAK/TIMEOUT defaults.
REQ-035 The block SHALL be a single module with no sub-module; the streak and watchdog counters are inline.

Verification
REQ-036 The bench SHALL cover: i_req only with addr 0x0000_0010 and m_ack one cycle after m_req, m_rdata = 0x0000_0013 -> i_valid with i_rdata = 0x0000_0013 and m_we = 0.
REQ-037 The bench SHALL cover: i_req and d_req both held continuously, with m_ack on every first SERVE cycle -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-038 The bench SHALL cover: store with d_addr 0x100 and d_wdata 0xDEAD_BEEF -> m_we = 1, m_addr = 0x100, m_wdata = 0xDEAD_BEEF, then d_valid on m_ack.
REQ-039 The bench SHALL cover: m_ack withheld -> after 16 SERVE cycles d_valid = 1, err = 1, d_rdata = 0, with m_req low the next cycle.
REQ-040 The bench SHALL cover: reset pulled low during SERVE_I -> m_req = 0 immediately, no i_valid, and a fresh grant after release.
REQ-041 The bench SHALL cover: a stray m_ack in IDLE -> no valid pulse and no state change.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
package riscv_mem_pkg;
  localparam int ADDR_W           = 32;
  localparam int DATA_W           = 32;
  localparam int MAX_D_STREAK_DEF = 4;
  localparam int TIMEOUT_DEF      = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;
endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store traffic onto one single-port memory with
// bounded data priority and a watchdog that aborts stalled accesses.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int MAX_D_STREAK = MAX_D_STREAK_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack
);
  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam int WDOG_W   = $clog2(TIMEOUT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [WDOG_W-1:0]   WDOG_LAST  = WDOG_W'(TIMEOUT - 1);

  arb_state_t          state, stateNext;
  logic [STREAK_W-1:0] streak;
  logic [WDOG_W-1:0]   wdog;
  logic                grantD, grantI, timedOut, servDone;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    grantD    = 1'b0;
    grantI    = 1'b0;
    timedOut  = 1'b0;
    servDone  = 1'b0;
    i_valid   = 1'b0;
    d_valid   = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    case (state)
      IDLE: begin
        // Data wins unless it has already hogged the port while a fetch waits.
        grantD = d_req && ((streak < STREAK_MAX) || !i_req);
        grantI = !grantD && i_req;
        if (grantD)      stateNext = SERVE_D;
        else if (grantI) stateNext = SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        timedOut = !m_ack && (wdog == WDOG_LAST);
        servDone = m_ack || timedOut;
        if (servDone) stateNext = IDLE;
        if (state == SERVE_I) begin
          i_valid = servDone;
          i_rdata = m_ack ? m_rdata : '0;
        end else begin
          d_valid = servDone;
          d_rdata = m_ack ? m_rdata : '0;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign m_req = (state != IDLE);
  assign err   = timedOut;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      streak  <= '0;
      wdog    <= '0;
    end else begin
      if (grantD) begin
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
        if (!i_req)                 streak <= '0;
        else if (streak != STREAK_MAX) streak <= streak + STREAK_W'(1);
      end else if (grantI) begin
        m_we    <= 1'b0;
        m_addr  <= i_addr;
        m_wdata <= '0;
        streak  <= '0;
      end
      // Age of the outstanding access; restarts at zero on every grant.
      if (state == IDLE) wdog <= '0;
      else               wdog <= wdog + WDOG_W'(1);
    end
  end
endmodule
